// File: rtl/amp_pkg.sv
// amp_pkg: shared types and helpers for the programmable-gain amplifier
// controller.
//   amp_state_e : frame sequencer states (IDLE, SETUP, SHIFT, HOLD)
//   DEF_*       : default parameter values
//   frame_w()   : serial frame width from channel count and code width
//   cnt_w()     : bits needed for a counter running 0..n-1 (at least 1)
package amp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } amp_state_e;

  localparam int unsigned DEF_NCH      = 32'd2;
  localparam int unsigned DEF_GAIN_W   = 32'd4;
  localparam int unsigned DEF_DIV      = 32'd2;
  localparam int unsigned DEF_CS_SETUP = 32'd1;
  localparam int unsigned DEF_CS_HOLD  = 32'd1;

  function automatic int unsigned frame_w(input int unsigned nch, input int unsigned gain_w);
    return nch * gain_w;
  endfunction

  // A counter that must reach n-1 without wrapping; one bit minimum so
  // that n=1 still yields a legal vector.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    if (n <= 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/amp_spi_shifter.sv
// amp_spi_shifter: SCK divider, bit counter and MOSI/MISO shift registers.
// Build option: AMP_READBACK_EN enables capture of miso into rx_data.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : latch din into the transmit register (frame accepted)
//   start       : begin shifting; next cycle SCK is low with bit W-1 on MOSI
//   din[W-1:0]  : frame to transmit, MSB first
//   miso        : serial data returned by the amplifier
//   sck, mosi   : registered SPI clock (idles low) and data
//   bit_done    : high in the final cycle of the last bit
//   rx_data     : word shifted in during the frame (0 without readback)
module amp_spi_shifter
  import amp_pkg::*;
#(
  parameter int unsigned W   = 32'd8,
  parameter int unsigned DIV = 32'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         start,
  input  logic [W-1:0] din,
  input  logic         miso,
  output logic         sck,
  output logic         mosi,
  output logic         bit_done,
  output logic [W-1:0] rx_data
);

  localparam int unsigned DIV_CW = cnt_w(DIV);
  localparam int unsigned BIT_CW = cnt_w(W);
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 32'd1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(W - 32'd1);

  logic [W-1:0]      tx_sr_r;
  logic [DIV_CW-1:0] div_cnt_r;
  logic [BIT_CW-1:0] bit_cnt_r;
  logic              active_r;
  logic              sck_r;
  logic              mosi_r;
  logic              bit_done_s;

  // Last cycle of the high phase of the final bit.
  assign bit_done_s = active_r && sck_r && (div_cnt_r == DIV_LAST) && (bit_cnt_r == BIT_LAST);

  // Shift engine: sck_r doubles as the phase flag (0 = low half, 1 = high half).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr_r   <= '0;
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      active_r  <= 1'b0;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
    end else if (load) begin
      tx_sr_r <= din;
    end else if (start) begin
      active_r  <= 1'b1;
      sck_r     <= 1'b0;
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      mosi_r    <= tx_sr_r[W-1];
      tx_sr_r   <= tx_sr_r << 1;
    end else if (active_r) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
        if (!sck_r) begin
          sck_r <= 1'b1;
        end else begin
          // Falling edge: either the frame ends (MOSI holds) or the next bit goes out.
          sck_r <= 1'b0;
          if (bit_cnt_r == BIT_LAST) begin
            active_r <= 1'b0;
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
            mosi_r    <= tx_sr_r[W-1];
            tx_sr_r   <= tx_sr_r << 1;
          end
        end
      end else begin
        div_cnt_r <= div_cnt_r + 1'b1;
      end
    end else begin
      sck_r <= 1'b0;
    end
  end

`ifdef AMP_READBACK_EN
  logic [W-1:0] rx_sr_r;

  // Capture miso in the first cycle of each high phase (the cycle SCK rises).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sr_r <= '0;
    end else if (active_r && sck_r && (div_cnt_r == '0)) begin
      rx_sr_r <= {rx_sr_r[W-2:0], miso};
    end else begin
      rx_sr_r <= rx_sr_r;
    end
  end

  assign rx_data = rx_sr_r;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

  assign sck      = sck_r;
  assign mosi     = mosi_r;
  assign bit_done = bit_done_s;

endmodule

// File: rtl/amp_gain_ctrl.sv
// amp_gain_ctrl: programs the channel gain codes of an SPI programmable-gain
// preamplifier in one frame and drives its shutdown pin.
// Build option: AMP_READBACK_EN captures the word shifted back on amp_dout
// into amp_rdata; without it amp_rdata stays 0. Timing is the same.
// Ports:
//   CLK50MHZ, RST    : clock, synchronous active-low reset
//   spi_sck/spi_mosi : SPI clock (idles low) and data, MSB first
//   amp_dout         : serial data from the amplifier
//   amp_cs           : chip select, active low
//   amp_shdn         : shutdown (1 = shut down), follows amp_shdn_req in IDLE
//   amp_trig         : one-cycle request to send amp_gain (accepted in IDLE)
//   amp_gain         : gain codes, channel NCH-1 in the MSBs
//   amp_shdn_req     : shutdown request level
//   amp_busy         : frame in progress
//   amp_done         : one-cycle pulse on return to IDLE
//   amp_rdata        : word shifted back by the amplifier
module amp_gain_ctrl
  import amp_pkg::*;
#(
  parameter int unsigned NCH      = DEF_NCH,
  parameter int unsigned GAIN_W   = DEF_GAIN_W,
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned CS_SETUP = DEF_CS_SETUP,
  parameter int unsigned CS_HOLD  = DEF_CS_HOLD
) (
  input  logic                    CLK50MHZ,
  input  logic                    RST,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  input  logic                    amp_dout,
  output logic                    amp_cs,
  output logic                    amp_shdn,
  input  logic                    amp_trig,
  input  logic [NCH*GAIN_W-1:0]   amp_gain,
  input  logic                    amp_shdn_req,
  output logic                    amp_busy,
  output logic                    amp_done,
  output logic [NCH*GAIN_W-1:0]   amp_rdata
);

  localparam int unsigned W      = frame_w(NCH, GAIN_W);
  localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_W  = cnt_w(PH_MAX);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 32'd1);

  amp_state_e     state_r;
  amp_state_e     next_state_s;
  logic [CNT_W-1:0] ph_cnt_r;
  logic           load_s;
  logic           start_s;
  logic           frame_end_s;
  logic           bit_done_s;
  logic [W-1:0]   rx_data_s;
  logic           cs_r;
  logic           busy_r;
  logic           done_r;
  logic           shdn_r;
  logic [W-1:0]   rdata_r;

  // State register.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Cycle counter for the CS setup and hold phases; restarts on every state change.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      ph_cnt_r <= '0;
    end else if (state_r != next_state_s) begin
      ph_cnt_r <= '0;
    end else if ((state_r == SETUP) || (state_r == HOLD)) begin
      ph_cnt_r <= ph_cnt_r + 1'b1;
    end else begin
      ph_cnt_r <= ph_cnt_r;
    end
  end

  // Next-state logic; triggers outside IDLE are dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (amp_trig) begin
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        if (ph_cnt_r == SETUP_LAST) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = SETUP;
        end
      end
      SHIFT: begin
        if (bit_done_s) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = SHIFT;
        end
      end
      HOLD: begin
        if (ph_cnt_r == HOLD_LAST) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Strobes to the shifter and the frame-end event.
  always_comb begin
    load_s      = (state_r == IDLE) && amp_trig;
    start_s     = (state_r == SETUP) && (ph_cnt_r == SETUP_LAST);
    frame_end_s = (state_r == HOLD) && (ph_cnt_r == HOLD_LAST);
  end

  // Registered outputs, derived from the upcoming state so they line up with it.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      cs_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      shdn_r  <= 1'b1;
      rdata_r <= '0;
    end else begin
      cs_r   <= (next_state_s == IDLE);
      busy_r <= (next_state_s != IDLE);
      done_r <= frame_end_s;
      // Shutdown only changes between frames, so a frame is never cut short.
      if (state_r == IDLE) begin
        shdn_r <= amp_shdn_req;
      end else begin
        shdn_r <= shdn_r;
      end
      if (frame_end_s) begin
        rdata_r <= rx_data_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  amp_spi_shifter #(
    .W   (W),
    .DIV (DIV)
  ) u_shifter (
    .clk      (CLK50MHZ),
    .rst_n    (RST),
    .load     (load_s),
    .start    (start_s),
    .din      (amp_gain),
    .miso     (amp_dout),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .bit_done (bit_done_s),
    .rx_data  (rx_data_s)
  );

  assign amp_cs    = cs_r;
  assign amp_busy  = busy_r;
  assign amp_done  = done_r;
  assign amp_shdn  = shdn_r;
  assign amp_rdata = rdata_r;

endmodule

// File: tb/tb_amp_gain_ctrl.sv
// Directed bench for amp_gain_ctrl: a default instance (NCH=2, GAIN_W=4,
// DIV=2) and a wide instance (NCH=4, GAIN_W=4, DIV=1) run side by side.
module tb_amp_gain_ctrl;

`ifdef AMP_READBACK_EN
  localparam logic [7:0]  EXP_RD1 = 8'h3C;
  localparam logic [15:0] EXP_RD2 = 16'hBEEF;
`else
  localparam logic [7:0]  EXP_RD1 = 8'h00;
  localparam logic [15:0] EXP_RD2 = 16'h0000;
`endif

  logic        CLK50MHZ;
  logic        RST;
  logic        amp_trig;
  logic        amp_shdn_req;
  logic        amp_dout;
  logic        amp_dout2;
  logic [7:0]  amp_gain;
  logic [15:0] amp_gain2;
  logic        spi_sck, spi_mosi, amp_cs, amp_shdn, amp_busy, amp_done;
  logic [7:0]  amp_rdata;
  logic        sck2, mosi2, cs2, shdn2, busy2, done2;
  logic [15:0] rdata2;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ret1;
  logic [15:0] ret2;
  int rises, rises2, highs, cs_low, done_cnt, first_done, last_done, done2_at, shdn_first1;
  logic [15:0] mosi_cap, mosi2_cap;
  logic [7:0]  rd_done;
  logic [15:0] rd2_done;
  logic cs_at_done, busy_at_done, cs_after_done, cs_rst, sck_rst, busy_rst;
  logic sck_prev, sck2_prev;

  amp_gain_ctrl u_dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .amp_dout(amp_dout), .amp_cs(amp_cs), .amp_shdn(amp_shdn), .amp_trig(amp_trig),
    .amp_gain(amp_gain), .amp_shdn_req(amp_shdn_req), .amp_busy(amp_busy),
    .amp_done(amp_done), .amp_rdata(amp_rdata)
  );

  amp_gain_ctrl #(.NCH(4), .GAIN_W(4), .DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut2 (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .spi_sck(sck2), .spi_mosi(mosi2),
    .amp_dout(amp_dout2), .amp_cs(cs2), .amp_shdn(shdn2), .amp_trig(amp_trig),
    .amp_gain(amp_gain2), .amp_shdn_req(amp_shdn_req), .amp_busy(busy2),
    .amp_done(done2), .amp_rdata(rdata2)
  );

  initial CLK50MHZ = 1'b0;
  always #10 CLK50MHZ = ~CLK50MHZ;

  task automatic step;
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs ncyc cycles after the current one (cycle k = T+k), acting as the
  // amplifier and collecting frame statistics; optional injections by cycle.
  task automatic watch(input int ncyc, input int trig_at, input logic [7:0] trig_gain,
                       input int rst_at, input int shdn_at, input bit retrig,
                       input logic [7:0] retrig_gain);
    rises = 0; rises2 = 0; highs = 0; cs_low = 0; done_cnt = 0; first_done = 0;
    last_done = 0; done2_at = 0; shdn_first1 = 0; mosi_cap = '0; mosi2_cap = '0;
    rd_done = '0; rd2_done = '0; cs_at_done = 1'b0; busy_at_done = 1'b1;
    cs_after_done = 1'b1; cs_rst = 1'b0; sck_rst = 1'b1; busy_rst = 1'b1;
    sck_prev = 1'b0; sck2_prev = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      amp_trig = 1'b0;
      RST = 1'b1;
      if (spi_sck && !sck_prev) begin
        mosi_cap = {mosi_cap[14:0], spi_mosi};
        amp_dout = ret1[7 - (rises % 8)];
        rises++;
      end
      if (sck2 && !sck2_prev) begin
        mosi2_cap = {mosi2_cap[14:0], mosi2};
        amp_dout2 = ret2[15 - (rises2 % 16)];
        rises2++;
      end
      if (spi_sck) highs++;
      if (!amp_cs) cs_low++;
      if ((first_done > 0) && (k == first_done + 1)) cs_after_done = amp_cs;
      if (amp_done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        last_done = k; rd_done = amp_rdata; cs_at_done = amp_cs; busy_at_done = amp_busy;
      end
      if (done2) begin
        done2_at = k; rd2_done = rdata2;
      end
      if (amp_shdn && (shdn_first1 == 0)) shdn_first1 = k;
      if (k == rst_at + 1) begin
        cs_rst = amp_cs; sck_rst = spi_sck; busy_rst = amp_busy;
      end
      sck_prev = spi_sck;
      sck2_prev = sck2;
      if (k == trig_at) begin amp_gain = trig_gain; amp_trig = 1'b1; end
      if (k == rst_at) RST = 1'b0;
      if (k == shdn_at) amp_shdn_req = 1'b1;
      if (retrig && amp_done && (done_cnt == 1)) begin amp_gain = retrig_gain; amp_trig = 1'b1; end
    end
  endtask

  initial begin
    RST = 1'b0; amp_trig = 1'b0; amp_shdn_req = 1'b0; amp_dout = 1'b0; amp_dout2 = 1'b0;
    amp_gain = 8'h00; amp_gain2 = 16'h0000; ret1 = 8'h3C; ret2 = 16'hBEEF;

    // Reset held for three cycles.
    step(); step(); step();
    chk("rst_cs", amp_cs, 1'b1);
    chk("rst_sck", spi_sck, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_shdn", amp_shdn, 1'b1);
    chk("rst_busy", amp_busy, 1'b0);
    chk("rst_done", amp_done, 1'b0);
    chk("rst_rdata", amp_rdata, 8'h00);
    RST = 1'b1;
    step();
    chk("shdn_after_release", amp_shdn, 1'b0);

    // Frame A5 at T; ignored trigger FF at T+10; shutdown request at T+5.
    amp_gain = 8'hA5; amp_gain2 = 16'h1234; amp_trig = 1'b1;
    watch(38, 10, 8'hFF, -1, 5, 1'b0, 8'h00);
    chk("f1_done_at", last_done, 35);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_rises", rises, 8);
    chk("f1_sck_high", highs, 16);
    chk("f1_mosi", mosi_cap, 16'h00A5);
    chk("f1_cs_low", cs_low, 34);
    chk("f1_cs_at_done", cs_at_done, 1'b1);
    chk("f1_busy_at_done", busy_at_done, 1'b0);
    chk("f1_rdata", rd_done, EXP_RD1);
    chk("f1_shdn_rise", shdn_first1, 36);
    chk("w16_done_at", done2_at, 35);
    chk("w16_rises", rises2, 16);
    chk("w16_mosi", mosi2_cap, 16'h1234);
    chk("w16_rdata", rd2_done, EXP_RD2);

    // Frame 5A, retriggered with C3 in the done cycle.
    amp_gain = 8'h5A; amp_trig = 1'b1;
    watch(75, -1, 8'h00, -1, -1, 1'b1, 8'hC3);
    chk("f2_first_done", first_done, 35);
    chk("f2_last_done", last_done, 70);
    chk("f2_done_cnt", done_cnt, 2);
    chk("f2_cs_high_1cyc", cs_after_done, 1'b0);
    chk("f2_cs_low", cs_low, 68);
    chk("f2_mosi", mosi_cap, 16'h5AC3);

    // Reset in cycle T+20 of a frame.
    amp_gain = 8'h0F; amp_trig = 1'b1;
    watch(40, -1, 8'h00, 20, -1, 1'b0, 8'h00);
    chk("f3_done_cnt", done_cnt, 0);
    chk("f3_cs_after_rst", cs_rst, 1'b1);
    chk("f3_sck_after_rst", sck_rst, 1'b0);
    chk("f3_busy_after_rst", busy_rst, 1'b0);

    // Full frame after the abort, sent while shut down.
    amp_gain = 8'h96; amp_trig = 1'b1;
    watch(37, -1, 8'h00, -1, -1, 1'b0, 8'h00);
    chk("f4_done_at", last_done, 35);
    chk("f4_done_cnt", done_cnt, 1);
    chk("f4_mosi", mosi_cap, 16'h0096);
    chk("f4_shdn_held", shdn_first1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amp_gain_ctrl.md
Name: amp_gain_ctrl

Overview:
Parametrised programmable-gain preamplifier controller, e.g. an LTC6912-class part on the ADC front end.
- Has its own SPI shift engine, so it no longer depends on a generic Spi instance.
- Serialises NCH channel gain codes into one frame and controls shutdown under request.
- Optionally captures the previous gain word the amplifier shifts back out.
- Sits between the ADC sequencer and the amplifier pins; shares spi_sck/spi_mosi with other SPI masters through the board-level mux.

Parameters:
NCH, 2, number of amplifier channels in the frame.
GAIN_W, 4, gain code bits per channel.
DIV, 2, CLK50MHZ cycles per SCK half-period (≥1).
CS_SETUP, 1, cycles CS low before first SCK edge (≥1).
CS_HOLD, 1, cycles CS held low after last SCK falling edge (≥1).

Ports:
CLK50MHZ  in  1  system clock; all logic rising-edge.
RST  in  1  synchronous, active-low reset.
spi_sck  out  1  SPI clock; idles low.
spi_mosi  out  1  serial data to amplifier, MSB first.
amp_dout  in  1  serial data from amplifier (previous gain word).
amp_cs  out  1  amplifier chip select, active low.
amp_shdn  out  1  amplifier shutdown; 1 = shut down.
amp_trig  in  1  one-cycle request to program amp_gain.
amp_gain  in  NCH*GAIN_W  gain codes; channel NCH-1 in the MSBs.
amp_shdn_req  in  1  level: 1 requests shutdown.
amp_busy  out  1  frame in progress.
amp_done  out  1  one-cycle pulse at frame end.
amp_rdata  out  NCH*GAIN_W  word shifted back by the amplifier (see Optional Feature).

Behaviour:
- Frame width W = NCH*GAIN_W. Counters are sized with $clog2 and must not wrap for any legal parameter set.
- Reset (RST=0, sampled on clock):
  - state IDLE; amp_cs=1, spi_sck=0, spi_mosi=0, amp_shdn=1, amp_busy=0, amp_done=0, amp_rdata=0.
  - Reset mid-frame aborts immediately; no partial done pulse.
- States:
  - IDLE→SETUP on amp_trig.
  - SETUP→SHIFT after CS_SETUP cycles.
  - SHIFT→HOLD after W bits.
  - HOLD→IDLE after CS_HOLD cycles.
- Trigger accept:
  - amp_trig is accepted only in IDLE, including the cycle amp_done is high.
  - The accepting cycle is T. amp_gain is latched into the shift register at T.
  - Triggers in any other state are ignored, not queued.
- Timing:
  - amp_cs=0 and amp_busy=1 from T+1 through the end of HOLD.
  - SHIFT: for each bit, spi_sck is low for DIV cycles, then high for DIV cycles.
  - spi_mosi presents bit W-1 from SHIFT entry and updates on each SCK falling edge. Amplifier samples on rising edge.
  - amp_dout is sampled on the CLK50MHZ cycle in which spi_sck rises.
  - HOLD keeps spi_sck=0 and spi_mosi at its last bit.
- Frame end:
  - On return to IDLE, in the same cycle: amp_cs=1, amp_busy=0, amp_done=1 for exactly one cycle, amp_rdata updated.
  - Latency T→done = 1+CS_SETUP+2*DIV*W+CS_HOLD. Defaults: 35 cycles.
  - Back-to-back frames: minimum CS high time is 1 cycle.
- Shutdown:
  - amp_shdn is registered from amp_shdn_req, but only while in IDLE.
  - A request arriving mid-frame takes effect in the cycle after amp_done.
  - Frames are still sent while shut down (the gain register stays writable).

Optional Feature:
Macro AMP_READBACK_EN.
- Defined: amp_dout bits are shifted in MSB first and transferred to amp_rdata at frame end.
- Undefined: amp_dout is unused and amp_rdata is held at 0.
- Timing and all other outputs are identical in both builds.

Decomposition:
- Package amp_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD);
  - width helper function for W and counter widths;
  - default parameter constants.
- Sub-module amp_spi_shifter: DIV divider, bit counter, MOSI/MISO shift registers. It is controlled by amp_gain_ctrl's FSM via load/start/bit_done strobes.

Test Plan:
- Reset: hold RST=0 for 3 cycles, then release → amp_cs=1, spi_sck=0, amp_shdn=1 during reset; amp_shdn follows amp_shdn_req=0 one cycle after release.
- Defaults, amp_gain=8'hA5 (b=A, a=5), trig at T → MOSI bits 1,0,1,0,0,1,0,1 on 8 rising SCK edges; 8 SCK pulses of 2 cycles high each; amp_done only at T+35.
- AMP_READBACK_EN: amplifier model returns 8'h3C on amp_dout during a frame → amp_rdata=8'h3C in the amp_done cycle. Build without the macro → amp_rdata=0.
- Trigger while busy at T+10 with 8'hFF → ignored; first frame's bits unchanged; only one done pulse. Trigger in the done cycle → new frame; CS high exactly 1 cycle.
- Reset at T+20 mid-frame → next cycle amp_cs=1, spi_sck=0, busy=0; no done pulse. The next trig runs a full 35-cycle frame.
- amp_shdn_req=1 at T+5 → amp_shdn stays 0 until the cycle after done, then 1. NCH=4, GAIN_W=4, DIV=1 → W=16 and latency 1+1+32+1=35.
